// File: rtl/riscv_pkg.sv
// Shared types and helpers for the RISC-V store buffer.
// Holds the entry layout and the size-code definitions.
package riscv_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [1:0]  sel;
        logic        valid;
    } sb_entry_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] sel);
        logic [3:0] nbytes;
        case (sel)
            SZ_B:    nbytes = 4'd1;
            SZ_H:    nbytes = 4'd2;
            SZ_W:    nbytes = 4'd4;
            default: nbytes = 4'd8;
        endcase
        return nbytes;
    endfunction

endpackage

// File: rtl/riscv_sb_overlap.sv
// Overlap check between one buffered store and an 8-byte load window.
// Plain unsigned compares; address wrap at the top of memory is not handled.
module riscv_sb_overlap
    import riscv_pkg::*;
(
    input  logic [63:0] i_e_addr,
    input  logic [1:0]  i_e_sel,
    input  logic        i_e_valid,
    input  logic [63:0] i_ld_addr,
    output logic        o_overlap
);

    logic [63:0] w_e_end;
    logic [63:0] w_ld_end;

    assign w_e_end   = i_e_addr + {60'd0, size_bytes(i_e_sel)};
    assign w_ld_end  = i_ld_addr + 64'd8;
    assign o_overlap = i_e_valid & (i_e_addr < w_ld_end) & (i_ld_addr < w_e_end);

endmodule

// File: rtl/riscv_store_buffer.sv
// Posted-store buffer: queues committed stores and drains them in order
// through the data memory's single shared port whenever loads allow it.
module riscv_store_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_riscv_sb_clk,
    input  logic        i_riscv_sb_rst,
    input  logic        i_riscv_sb_push,
    input  logic [1:0]  i_riscv_sb_sel,
    input  logic [63:0] i_riscv_sb_addr,
    input  logic [63:0] i_riscv_sb_data,
    input  logic        i_riscv_sb_ld_en,
    input  logic [63:0] i_riscv_sb_ld_addr,
    output logic        o_riscv_sb_full,
    output logic        o_riscv_sb_empty,
    output logic        o_riscv_sb_ld_hazard,
    output logic        o_riscv_dm_wen,
    output logic [1:0]  o_riscv_dm_sel,
    output logic [63:0] o_riscv_dm_wdata,
    output logic [63:0] o_riscv_dm_waddr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    sb_entry_t        r_entries [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;

    logic [DEPTH-1:0] w_ovl;
    logic             w_full;
    logic             w_empty;
    logic             w_hazard;
    logic             w_push;
    logic             w_drain;
    sb_entry_t        w_head;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ovl
        riscv_sb_overlap u_overlap (
            .i_e_addr  (r_entries[g].addr),
            .i_e_sel   (r_entries[g].sel),
            .i_e_valid (r_entries[g].valid),
            .i_ld_addr (i_riscv_sb_ld_addr),
            .o_overlap (w_ovl[g])
        );
    end

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_hazard = i_riscv_sb_ld_en & (|w_ovl);
    assign w_push   = i_riscv_sb_push & ~w_full;
    // A hazarding load can only make progress once the overlapping stores retire.
    assign w_drain  = ~w_empty & (~i_riscv_sb_ld_en | w_hazard);
    assign w_head   = r_entries[r_rd_ptr];

    assign o_riscv_sb_full      = w_full;
    assign o_riscv_sb_empty     = w_empty;
    assign o_riscv_sb_ld_hazard = w_hazard;

    always_comb begin
        o_riscv_dm_wen   = 1'b0;
        o_riscv_dm_sel   = SZ_B;
        o_riscv_dm_wdata = '0;
        o_riscv_dm_waddr = '0;
        if (w_drain) begin
            o_riscv_dm_wen   = 1'b1;
            o_riscv_dm_sel   = w_head.sel;
            o_riscv_dm_wdata = w_head.data;
            o_riscv_dm_waddr = w_head.addr;
        end else if (i_riscv_sb_ld_en) begin
            o_riscv_dm_waddr = i_riscv_sb_ld_addr;
        end
    end

    // Push and pop never target the same slot: that would need count 0 or DEPTH.
    always_ff @(posedge i_riscv_sb_clk or posedge i_riscv_sb_rst) begin
        if (i_riscv_sb_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_entries[r_wr_ptr] <= '{addr:  i_riscv_sb_addr,
                                         data:  i_riscv_sb_data,
                                         sel:   i_riscv_sb_sel,
                                         valid: 1'b1};
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_drain) begin
                r_entries[r_rd_ptr].valid <= 1'b0;
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
